// File: rtl/square_decode_if.sv
// square_decode_if: sample stream into the decoder, tone-detect status back out
interface square_decode_if;
    logic        sample_valid;
    logic [15:0] sample;
    logic [15:0] threshold;
    logic        tone_valid;
    logic [20:0] half_period;
    logic [15:0] volume;
    logic        update;
    modport master(output sample_valid, sample, threshold, input tone_valid, half_period, volume, update);
    modport slave(input sample_valid, sample, threshold, output tone_valid, half_period, volume, update);
endinterface

// File: rtl/square_decode.sv
// square_decode: slices a sample stream and measures square-tone half-period and peak amplitude
module square_decode #(
    parameter int unsigned TOL       = 0,
    parameter int unsigned LOCK_RUNS = 2,
    parameter logic [20:0] TIMEOUT   = 21'h1FFFFF
) (
    input logic            clk,
    input logic            rst,
    square_decode_if.slave bus
);
    localparam int MW = $clog2(LOCK_RUNS + 1);
    typedef enum logic [1:0] {IDLE, ALIGN, TRACK, LOCKED} state_t;
    state_t state, state_n;
    logic level_prev, level, edg, rise, fall, timeout, hit, tone_n, upd_n;
    logic [20:0] run_cnt, cand, cand_n, hp_n, m, diff;
    logic [15:0] peak, vol_n;
    logic [MW-1:0] match_cnt, match_n, match_inc;
    assign level = bus.sample > bus.threshold;
    assign edg = bus.sample_valid && level != level_prev;
    assign rise = edg && level;
    assign fall = edg && !level;
    assign m = run_cnt - 21'd1;
    assign diff = m > cand ? m - cand : cand - m;
    assign hit = diff <= 21'(TOL);
    assign match_inc = match_cnt == '1 ? match_cnt : match_cnt + MW'(1);
    // an edge always wins over a timeout on the same sample
    assign timeout = bus.sample_valid && !edg && run_cnt == TIMEOUT && state != IDLE;
    always_comb begin
        state_n = state;
        cand_n = cand;
        match_n = match_cnt;
        tone_n = bus.tone_valid;
        hp_n = bus.half_period;
        vol_n = bus.volume;
        upd_n = 1'b0;
        if (edg) begin
            if (fall && (state == TRACK || state == LOCKED)) vol_n = peak;
            case (state)
                IDLE: state_n = ALIGN;
                ALIGN: begin
                    cand_n = m;
                    match_n = MW'(1);
                    state_n = TRACK;
                end
                TRACK: begin
                    cand_n = hit ? cand : m;
                    match_n = hit ? match_inc : MW'(1);
                    if (hit && match_inc == MW'(LOCK_RUNS)) begin
                        state_n = LOCKED;
                        tone_n = 1'b1;
                        hp_n = cand;
                        upd_n = 1'b1;
                    end
                end
                LOCKED: begin
                    cand_n = m;
                    hp_n = hit ? m : bus.half_period;
                    upd_n = hit;
                    if (!hit) begin
                        state_n = TRACK;
                        match_n = MW'(1);
                        tone_n = 1'b0;
                    end
                end
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            tone_n = 1'b0;
            hp_n = '0;
            vol_n = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            level_prev <= 1'b0;
            run_cnt <= '0;
            cand <= '0;
            match_cnt <= '0;
            peak <= '0;
            bus.tone_valid <= 1'b0;
            bus.half_period <= '0;
            bus.volume <= '0;
            bus.update <= 1'b0;
        end else if (bus.sample_valid) begin
            state <= state_n;
            level_prev <= level;
            run_cnt <= edg ? 21'd1 : run_cnt == TIMEOUT ? run_cnt : run_cnt + 21'd1;
            cand <= cand_n;
            match_cnt <= match_n;
            peak <= rise || (level && bus.sample > peak) ? bus.sample : peak;
            bus.tone_valid <= tone_n;
            bus.half_period <= hp_n;
            bus.volume <= vol_n;
            bus.update <= upd_n;
        end else begin
            bus.update <= 1'b0;
        end
    end
endmodule
